// File: rtl/intadd_pkg.sv
// Shared definitions for the int8 nibble-plane adder array and its merge path.
//   LANES / NIB_W / DW : plane geometry (32 lanes x 4b = 128b beats)
//   merge_mode_e       : MERGE8 (two int8 beats) or NARROW4 (one saturated 4b beat)
//   merge_st_e         : output sequencer states
//   sat4()             : int8/uint8 -> 4b saturation, shared with the add8 datapath
package intadd_pkg;

  localparam int unsigned LANES = 32;
  localparam int unsigned NIB_W = 4;
  localparam int unsigned DW    = LANES * NIB_W;

  typedef enum logic {
    MERGE8  = 1'b0,
    NARROW4 = 1'b1
  } merge_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } merge_st_e;

  // sgn=1: clamp int8 to [-8,7]; sgn=0: clamp uint8 to [0,15].
  // A signed value fits in 4b only when bits [7:3] are all equal.
  function automatic logic [3:0] sat4(input logic [7:0] v, input logic sgn);
    logic [3:0] r;
    if (sgn) begin
      if (!v[7] && (v[6:3] != 4'b0000))
        r = 4'h7;
      else if (v[7] && (v[6:3] != 4'b1111))
        r = 4'h8;
      else
        r = v[3:0];
    end else begin
      r = (v[7:4] != 4'h0) ? 4'hF : v[3:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/nibble_sat4_lane.sv
// One lane of the NARROW4 path: saturates an 8-bit lane value to 4 bits.
//   b   : lane byte {hi nibble, lo nibble}
//   sgn : 1 = signed saturation, 0 = unsigned saturation
//   q   : saturated 4-bit result
module nibble_sat4_lane
  import intadd_pkg::*;
(
  input  logic [7:0] b,
  input  logic       sgn,
  output logic [3:0] q
);

  always_comb begin
    q = sat4(b, sgn);
  end

endmodule

// File: rtl/nibble_merge8.sv
// Rebuilds int8 lane data from split low/high nibble planes as a valid/ready stream.
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid / in_ready : input handshake for src_lo, src_hi, mode, i_sign_d
//   src_lo / src_hi     : 128b nibble planes, lane k at [4k+:4]
//   mode                : 0 = MERGE8 (two beats), 1 = NARROW4 (one saturated beat)
//   i_sign_d            : NARROW4 saturation signedness
//   out_valid/out_ready : output handshake
//   dst, out_last       : registered output beat, last-beat flag
module nibble_merge8
  import intadd_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  src_lo,
  input  logic [127:0]  src_hi,
  input  logic          mode,
  input  logic          i_sign_d,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  dst,
  output logic          out_last
);

  merge_st_e      state;
  merge_mode_e    mode_q;
  logic [DW-1:0]  hold_hi;
  logic [2*DW-1:0] bytes_in;
  logic [DW-1:0]  narrow;
  logic           in_fire;
  logic           out_fire;

  // Lane bytes and their saturated form are built straight from the input
  // pins so BEAT0 can be registered on in_fire. Signedness is consumed at
  // that point, so it never needs its own flag register; only the upper
  // half of the vector must be held for BEAT1.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign bytes_in[8*k +: 8] = {src_hi[NIB_W*k +: NIB_W], src_lo[NIB_W*k +: NIB_W]};

    nibble_sat4_lane u_sat (
      .b   (bytes_in[8*k +: 8]),
      .sgn (i_sign_d),
      .q   (narrow[NIB_W*k +: NIB_W])
    );
  end

  assign out_fire = out_valid & out_ready;
  assign in_ready = ~rst & ((state == IDLE) | (out_fire & out_last));
  assign in_fire  = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mode_q    <= MERGE8;
      hold_hi   <= '0;
      dst       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (in_fire) begin
      // Covers both the IDLE start and the no-bubble reload on a last beat.
      state     <= BEAT0;
      mode_q    <= merge_mode_e'(mode);
      hold_hi   <= bytes_in[2*DW-1:DW];
      dst       <= mode ? narrow : bytes_in[DW-1:0];
      out_valid <= 1'b1;
      out_last  <= mode;
    end else if (out_fire) begin
      if ((state == BEAT0) && (mode_q == MERGE8)) begin
        state    <= BEAT1;
        dst      <= hold_hi;
        out_last <= 1'b1;
      end else begin
        state     <= IDLE;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nibble_merge8.sv
module tb_nibble_merge8;

  typedef struct packed {
    logic [127:0] d;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] src_lo;
  logic [127:0] src_hi;
  logic         mode;
  logic         i_sign_d;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] dst;
  logic         out_last;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  exp_t sb[$];
  int   out_cyc[$];
  int   in_cyc[$];

  nibble_merge8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .src_lo    (src_lo),
    .src_hi    (src_hi),
    .mode      (mode),
    .i_sign_d  (i_sign_d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dst       (dst),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every accepted output beat is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      exp_t e;
      checks++;
      out_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: got dst=%h last=%0b, required no beat", dst, out_last);
      end else begin
        e = sb.pop_front();
        if (dst !== e.d || out_last !== e.last) begin
          errors++;
          $display("FAIL beat: got dst=%h last=%0b, required dst=%h last=%0b",
                   dst, out_last, e.d, e.last);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic push(input logic [127:0] d, input logic last);
    exp_t e;
    e.d = d;
    e.last = last;
    sb.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [127:0] lo, input logic [127:0] hi,
                      input logic m, input logic s);
    int n;
    src_lo = lo;
    src_hi = hi;
    mode = m;
    i_sign_d = s;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for 50 cycles, required 1");
    end else begin
      in_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Flip sideband pins: they must be ignored mid-vector.
    mode = ~m;
    i_sign_d = ~s;
    src_lo = ~lo;
    src_hi = ~hi;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending, required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask

  logic [7:0] bb_byte [8] = '{8'h00, 8'h07, 8'h08, 8'hF8, 8'hF7, 8'hFF, 8'h03, 8'h10};
  logic       bb_sgn  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [3:0] bb_exp  [8] = '{4'h0, 4'h7, 4'h7, 4'h8, 4'h8, 4'hF, 4'h3, 4'hF};

  initial begin
    int n0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    src_lo = '0;
    src_hi = '0;
    mode = 1'b0;
    i_sign_d = 1'b0;

    #2;
    chk("rst_out_valid", {127'b0, out_valid}, 128'h0);
    chk("rst_out_last", {127'b0, out_last}, 128'h0);
    chk("rst_dst", dst, 128'h0);
    chk("rst_in_ready", {127'b0, in_ready}, 128'h0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_in_ready", {127'b0, in_ready}, 128'h1);

    // MERGE8: lane0 = 7F, lane16 = 81
    n0 = out_cyc.size();
    push(128'h7F, 1'b0);
    push(128'h81, 1'b1);
    send(128'h1_0000_0000_0000_000F, 128'h8_0000_0000_0000_0007, 1'b0, 1'b0);
    drain();
    chk("merge_latency", 128'(out_cyc[n0]), 128'(in_cyc[in_cyc.size()-1] + 1));
    chk("merge_two_cycles", 128'(out_cyc[n0+1]), 128'(out_cyc[n0] + 1));

    // NARROW4 signed: 7F, 80, FD, 05
    push(128'h5D87, 1'b1);
    send(128'h5D0F, 128'h0F87, 1'b1, 1'b1);
    drain();

    // NARROW4 unsigned: 7F, 0A, 10
    push(128'hFAF, 1'b1);
    send(128'h0AF, 128'h107, 1'b1, 1'b0);
    drain();

    // MERGE8 full pattern: lane k byte = {5, k mod 16}
    push(128'h5F5E5D5C5B5A59585756555453525150, 1'b0);
    push(128'h5F5E5D5C5B5A59585756555453525150, 1'b1);
    send(128'hFEDCBA9876543210_FEDCBA9876543210, {32{4'h5}}, 1'b0, 1'b1);
    drain();

    // 8 back-to-back NARROW4 vectors on lane0
    n0 = out_cyc.size();
    for (int i = 0; i < 8; i++) begin
      logic [7:0] v;
      v = bb_byte[i];
      push({124'b0, bb_exp[i]}, 1'b1);
      send({124'b0, v[3:0]}, {124'b0, v[7:4]}, 1'b1, bb_sgn[i]);
    end
    drain();
    for (int i = 0; i < 7; i++)
      chk("burst_consecutive", 128'(out_cyc[n0+i+1]), 128'(out_cyc[n0+i] + 1));

    // Backpressure on BEAT1, then release together with a new vector
    push(128'h7F, 1'b0);
    push(128'h81, 1'b1);
    send(128'h1_0000_0000_0000_000F, 128'h8_0000_0000_0000_0007, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_dst", dst, 128'h81);
      chk("bp_last", {127'b0, out_last}, 128'h1);
      chk("bp_in_ready", {127'b0, in_ready}, 128'h0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    push(128'h70, 1'b1);
    send(128'h20, 128'h40, 1'b1, 1'b1);
    drain();
    chk("bp_no_bubble", 128'(out_cyc[out_cyc.size()-1]), 128'(out_cyc[out_cyc.size()-2] + 1));

    // Reset pulse during BEAT1 drops the vector
    push(128'h7F, 1'b0);
    push(128'h81, 1'b1);
    send(128'h1_0000_0000_0000_000F, 128'h8_0000_0000_0000_0007, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("pre_rst_valid", {127'b0, out_valid}, 128'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", {127'b0, out_valid}, 128'h0);
    chk("async_rst_dst", dst, 128'h0);
    sb.delete();
    #2 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {127'b0, in_ready}, 128'h1);
    chk("post_rst_valid", {127'b0, out_valid}, 128'h0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale_beat", {127'b0, out_valid}, 128'h0);
    end
    @(posedge clk);
    #1;

    push(128'h5D87, 1'b1);
    send(128'h5D0F, 128'h0F87, 1'b1, 1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

endmodule
